dispatch_queue: RTL and testbench

In-order dispatch buffer that sits directly after the out-of-order core's instruction control decoder. It accepts decoded control bundles over a valid/ready handshake and drops no-ops at entry. It buffers up to DEPTH operations and issues the oldest one to the execution class that owns it: ALU/shift, multiply/divide, memory, or branch. It is the consuming end of the decoder's control-signal interface and performs all class steering and stall handling for that interface.

---
 rtl/dispatch_queue.sv | 149 ++++++++++++++
 tb/tb_dispatch_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// In-order dispatch buffer: accepts decoded control bundles, drops no-ops at entry,
// and presents the oldest op to the one execution class (ALU, MD, MEM, BR) that owns it.
module dispatch_queue #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TAGW-1:0] in_tag,
  input  logic [4:0]      in_regRD,
  input  logic [2:0]      in_ALUOp,
  input  logic [1:0]      in_whichMath,
  input  logic            in_leftShift,
  input  logic [2:0]      in_commandType,
  input  logic            in_regWrite,
  input  logic            in_memWrite,
  input  logic            in_read_enable,
  input  logic            in_brTaken,
  output logic            alu_valid,
  input  logic            alu_ready,
  output logic            md_valid,
  input  logic            md_ready,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            br_valid,
  input  logic            br_ready,
  output logic [TAGW-1:0] out_tag,
  output logic [4:0]      out_regRD,
  output logic [2:0]      out_ALUOp,
  output logic [1:0]      out_whichMath,
  output logic            out_leftShift,
  output logic [2:0]      out_commandType,
  output logic            out_regWrite,
  output logic            out_memWrite,
  output logic            out_read_enable,
  output logic [15:0]     issued_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = TAGW + 17;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {CLS_ALU = 2'd0, CLS_MD = 2'd1, CLS_MEM = 2'd2, CLS_BR = 2'd3} cls_e;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   issued_q, issued_d;
  logic [PW-1:0] mem_q [DEPTH];
  logic [PW-1:0] mem_d [DEPTH];
  cls_e          cls_q [DEPTH];
  cls_e          cls_d [DEPTH];
  logic [PW-1:0] last_q, last_d;
  logic [PW-1:0] head_w, in_w;
  cls_e          in_cls, head_cls;
  logic          in_nop, has_head, head_ready, enq, deq;

  assign in_w = {in_tag, in_regRD, in_ALUOp, in_whichMath, in_leftShift,
                 in_commandType, in_regWrite, in_memWrite, in_read_enable};

  // Class priority: branch, memory, mult/div, ALU; anything else is a no-op.
  always_comb begin
    in_nop = 1'b0;
    in_cls = CLS_ALU;
    if (in_commandType == 3'd3 || in_commandType >= 3'd5 || in_brTaken) in_cls = CLS_BR;
    else if (in_memWrite || in_read_enable)                              in_cls = CLS_MEM;
    else if (in_whichMath[1])                                            in_cls = CLS_MD;
    else if (in_regWrite)                                                in_cls = CLS_ALU;
    else                                                                 in_nop = 1'b1;
  end

  assign in_ready = (count_q < FULL);

  always_comb begin
    has_head  = (count_q != '0);
    head_cls  = cls_q[rd_ptr_q];
    head_w    = has_head ? mem_q[rd_ptr_q] : last_q;
    alu_valid = has_head && (head_cls == CLS_ALU);
    md_valid  = has_head && (head_cls == CLS_MD);
    mem_valid = has_head && (head_cls == CLS_MEM);
    br_valid  = has_head && (head_cls == CLS_BR);
    case (head_cls)
      CLS_ALU: head_ready = alu_ready;
      CLS_MD:  head_ready = md_ready;
      CLS_MEM: head_ready = mem_ready;
      default: head_ready = br_ready;
    endcase
    deq = has_head && head_ready;
    enq = in_valid && in_ready && !in_nop;
  end

  always_comb begin
    mem_d    = mem_q;
    cls_d    = cls_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    issued_d = issued_q;
    last_d   = head_w;
    if (enq) begin
      mem_d[wr_ptr_q] = in_w;
      cls_d[wr_ptr_q] = in_cls;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      issued_d = issued_q + 16'd1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Mispredict recovery discards both the same-cycle enqueue and issue.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      issued_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      issued_q <= '0;
      last_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    cls_q <= cls_d;
  end

  assign {out_tag, out_regRD, out_ALUOp, out_whichMath, out_leftShift,
          out_commandType, out_regWrite, out_memWrite, out_read_enable} = head_w;
  assign issued_count = issued_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized bench for dispatch_queue: a queue-based reference model predicts the head
// entry, valids, in_ready and issued_count each cycle and is compared on the falling edge.
module tb_dispatch_queue;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
  localparam int FW    = TAGW + 17;

  logic clk, reset, flush, in_valid, in_ready;
  logic [TAGW-1:0] in_tag, out_tag;
  logic [4:0] in_regRD, out_regRD;
  logic [2:0] in_ALUOp, out_ALUOp, in_commandType, out_commandType;
  logic [1:0] in_whichMath, out_whichMath;
  logic in_leftShift, out_leftShift, in_regWrite, out_regWrite;
  logic in_memWrite, out_memWrite, in_read_enable, out_read_enable, in_brTaken;
  logic alu_valid, alu_ready, md_valid, md_ready, mem_valid, mem_ready, br_valid, br_ready;
  logic [15:0] issued_count;

  dispatch_queue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_regRD(in_regRD),
    .in_ALUOp(in_ALUOp), .in_whichMath(in_whichMath), .in_leftShift(in_leftShift),
    .in_commandType(in_commandType), .in_regWrite(in_regWrite), .in_memWrite(in_memWrite),
    .in_read_enable(in_read_enable), .in_brTaken(in_brTaken),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .md_valid(md_valid), .md_ready(md_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .br_valid(br_valid), .br_ready(br_ready),
    .out_tag(out_tag), .out_regRD(out_regRD), .out_ALUOp(out_ALUOp),
    .out_whichMath(out_whichMath), .out_leftShift(out_leftShift),
    .out_commandType(out_commandType), .out_regWrite(out_regWrite),
    .out_memWrite(out_memWrite), .out_read_enable(out_read_enable),
    .issued_count(issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // 0 ALU, 1 MD, 2 MEM, 3 BR, 4 no-op
  function automatic int cls_of(input logic [2:0] ct, input logic bt, input logic mw,
                                input logic re, input logic [1:0] wm, input logic rw);
    if (ct == 3 || ct == 5 || ct == 6 || ct == 7 || bt) return 3;
    if (mw || re) return 2;
    if (wm == 2 || wm == 3) return 1;
    if (rw) return 0;
    return 4;
  endfunction

  typedef struct { int cls; logic [FW-1:0] f; } ent_t;
  ent_t mq[$];
  logic [15:0] m_icnt = '0;
  logic [FW-1:0] m_last = '0;
  bit chk_en = 0;

  wire [FW-1:0] in_vec  = {in_tag, in_regRD, in_ALUOp, in_whichMath, in_leftShift,
                           in_commandType, in_regWrite, in_memWrite, in_read_enable};
  wire [FW-1:0] out_vec = {out_tag, out_regRD, out_ALUOp, out_whichMath, out_leftShift,
                           out_commandType, out_regWrite, out_memWrite, out_read_enable};
  wire [3:0] rdy_vec = {br_ready, mem_ready, md_ready, alu_ready};
  wire [3:0] vld_vec = {br_valid, mem_valid, md_valid, alu_valid};

  always @(negedge clk) begin
    logic [3:0] ev;
    logic [FW-1:0] ef;
    logic rdy;
    int c;
    rdy = (mq.size() < DEPTH);
    ev = 4'b0000;
    ef = m_last;
    if (mq.size() > 0) begin
      ev = 4'b0001 << mq[0].cls;
      ef = mq[0].f;
    end
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("valids", 64'(vld_vec), 64'(ev));
      chk("head_fields", 64'(out_vec), 64'(ef));
      chk("issued_count", 64'(issued_count), 64'(m_icnt));
    end
    m_last = ef;
    if (reset || flush) begin
      mq.delete();
      m_icnt = '0;
      if (reset) begin
        m_last = '0;
        chk_en = 1;
      end
    end else begin
      if (mq.size() > 0 && rdy_vec[mq[0].cls[1:0]]) begin
        void'(mq.pop_front());
        m_icnt = m_icnt + 16'd1;
      end
      c = cls_of(in_commandType, in_brTaken, in_memWrite, in_read_enable, in_whichMath, in_regWrite);
      if (in_valid && rdy && c != 4) mq.push_back('{cls: c, f: in_vec});
    end
  end

  bit tog = 0;
  bit rnd = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) {alu_ready, md_ready, mem_ready, br_ready} = ~{alu_ready, md_ready, mem_ready, br_ready};
    if (rnd) {alu_ready, md_ready, mem_ready, br_ready} = 4'($urandom);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_op(input logic [3:0] tag, input logic [2:0] ct, input logic [1:0] wm,
                        input logic rw, input logic mw, input logic re, input logic bt);
    in_tag = tag; in_commandType = ct; in_whichMath = wm; in_regWrite = rw;
    in_memWrite = mw; in_read_enable = re; in_brTaken = bt;
    in_regRD = 5'($urandom); in_ALUOp = 3'($urandom); in_leftShift = 1'($urandom);
  endtask

  task automatic send(input logic [3:0] tag, input logic [2:0] ct, input logic [1:0] wm,
                      input logic rw, input logic mw, input logic re, input logic bt);
    bit acc;
    set_op(tag, ct, wm, rw, mw, re, bt);
    in_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    if (!acc) begin
      ncmp++;
      nfail++;
      $display("FAIL send_timeout: tag %0h not accepted, want accepted", tag);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0;
    {alu_ready, md_ready, mem_ready, br_ready} = 4'b0000;
    set_op(4'd0, 3'd0, 2'd0, 0, 0, 0, 0);
    idle(3);
    reset = 0;
    idle(1);

    // One op per class, all destinations ready.
    {alu_ready, md_ready, mem_ready, br_ready} = 4'b1111;
    send(4'd1, 3'd0, 2'd0, 1, 0, 0, 0);
    send(4'd2, 3'd0, 2'd2, 1, 0, 0, 0);
    send(4'd3, 3'd0, 2'd0, 1, 0, 1, 0);
    send(4'd4, 3'd5, 2'd0, 0, 0, 0, 0);
    idle(3);
    chk("issued_after_four", 64'(issued_count), 64'd4);

    // Fill to capacity while ALU stalls; a fifth op must wait.
    alu_ready = 0;
    for (int i = 5; i < 9; i++) send(4'(i), 3'd0, 2'd0, 1, 0, 0, 0);
    set_op(4'd9, 3'd0, 2'd0, 1, 0, 0, 0);
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_in_ready", 64'(in_ready), 64'd0);
    end
    alu_ready = 1;
    send(4'd9, 3'd0, 2'd0, 1, 0, 0, 0);
    idle(6);

    // Stalled DIV blocks a younger ADD.
    md_ready = 0;
    send(4'd10, 3'd0, 2'd3, 1, 0, 0, 0);
    send(4'd11, 3'd0, 2'd0, 1, 0, 0, 0);
    idle(3);
    chk("blocked_alu_valid", 64'(alu_valid), 64'd0);
    chk("stalled_md_valid", 64'(md_valid), 64'd1);
    md_ready = 1;
    idle(4);

    // No-op between two ADDs is accepted but not stored.
    send(4'd12, 3'd0, 2'd0, 1, 0, 0, 0);
    send(4'd13, 3'd0, 2'd0, 0, 0, 0, 0);
    send(4'd14, 3'd0, 2'd0, 1, 0, 0, 0);
    idle(4);

    // Flush with a concurrent enqueue.
    {alu_ready, md_ready, mem_ready, br_ready} = 4'b0000;
    send(4'd1, 3'd0, 2'd0, 1, 0, 0, 0);
    send(4'd2, 3'd0, 2'd2, 1, 0, 0, 0);
    send(4'd3, 3'd0, 2'd0, 0, 1, 0, 0);
    set_op(4'd4, 3'd0, 2'd0, 1, 0, 0, 0);
    in_valid = 1; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_valids", 64'(vld_vec), 64'd0);
    chk("flush_issued", 64'(issued_count), 64'd0);
    {alu_ready, md_ready, mem_ready, br_ready} = 4'b1111;
    idle(3);

    // Ten ops across classes with toggling readies.
    tog = 1;
    for (int i = 0; i < 10; i++)
      case (i % 4)
        0: send(4'(i), 3'd0, 2'd1, 1, 0, 0, 0);
        1: send(4'(i), 3'd0, 2'd3, 1, 0, 0, 0);
        2: send(4'(i), 3'd0, 2'd0, 0, 1, 0, 0);
        default: send(4'(i), 3'd7, 2'd0, 0, 0, 0, 0);
      endcase
    idle(12);
    tog = 0;

    // Random traffic with occasional flush and one mid-run reset.
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset = 1; tick(); reset = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        flush = 1; in_valid = 1'($urandom); tick(); flush = 0; in_valid = 0;
      end else if ($urandom_range(0, 2) != 0) begin
        send(4'($urandom), ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0, 2'($urandom),
             1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0);
      end else begin
        tick();
      end
    end
    rnd = 0;

    // Issue counter wraps past 0xFFFF.
    {alu_ready, md_ready, mem_ready, br_ready} = 4'b1111;
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 65540; i++) send(4'(i), 3'd0, 2'd0, 1, 0, 0, 0);
    idle(4);
    chk("issued_wrap", 64'(issued_count), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end
endmodule
